// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep sequencer driving the DDS step_in/SET load port.
// Optional SWEEP_PHASE_ALIGN_EN inserts an ALIGN state that waits for zero_address.
module dds_sweep_ctrl #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DWELL_WIDTH   = 16
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     start,
    input  logic                     abort,
    input  logic [ADDRESS_WIDTH-1:0] start_step,
    input  logic [ADDRESS_WIDTH-1:0] stop_step,
    input  logic [ADDRESS_WIDTH-1:0] step_inc,
    input  logic [DWELL_WIDTH-1:0]   dwell,
    input  logic                     zero_address,
    output logic [ADDRESS_WIDTH-1:0] step_out,
    output logic                     SET,
    output logic                     busy,
    output logic                     done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ALIGN = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_DWELL = 3'd3;
    localparam logic [2:0] S_NEXT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

`ifdef SWEEP_PHASE_ALIGN_EN
    localparam logic [2:0] S_FIRST = S_ALIGN;
`else
    localparam logic [2:0] S_FIRST = S_LOAD;
    logic unused_zero_address;
    assign unused_zero_address = zero_address;
`endif

    logic [2:0]               state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] cur_q, cur_d;
    logic [ADDRESS_WIDTH-1:0] stop_q, stop_d;
    logic [ADDRESS_WIDTH-1:0] inc_q, inc_d;
    logic [DWELL_WIDTH-1:0]   dwell_q, dwell_d;
    logic [DWELL_WIDTH-1:0]   cnt_q, cnt_d;
    logic [ADDRESS_WIDTH-1:0] step_out_q, step_out_d;
    logic                     set_q, set_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [ADDRESS_WIDTH:0]   sum;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        stop_d  = stop_q;
        inc_d   = inc_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        sum     = {1'b0, cur_q} + {1'b0, inc_q};

        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    stop_d  = stop_step;
                    inc_d   = (step_inc == '0) ? ADDRESS_WIDTH'(1) : step_inc;
                    dwell_d = (dwell == '0) ? DWELL_WIDTH'(1) : dwell;
                    cur_d   = start_step;
                    state_d = S_FIRST;
                end
            end
`ifdef SWEEP_PHASE_ALIGN_EN
            S_ALIGN: begin
                if (zero_address) state_d = S_LOAD;
            end
`endif
            S_LOAD: begin
                cnt_d   = dwell_q;
                state_d = S_DWELL;
            end
            S_DWELL: begin
                cnt_d = cnt_q - DWELL_WIDTH'(1);
                if (cnt_q == DWELL_WIDTH'(1)) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (cur_q >= stop_q) begin
                    state_d = S_DONE;
                end else begin
                    // The carry bit in sum keeps the clamp correct near full scale
                    cur_d   = (sum > {1'b0, stop_q}) ? stop_q
                                                     : sum[ADDRESS_WIDTH-1:0];
                    state_d = S_FIRST;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort && state_q != S_IDLE) state_d = S_IDLE;
    end

    // Outputs are registered copies of the next-state decode
    always_comb begin
        set_d      = (state_d == S_LOAD);
        step_out_d = (state_d == S_LOAD) ? cur_d : step_out_q;
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            cur_q      <= '0;
            stop_q     <= '0;
            inc_q      <= '0;
            dwell_q    <= '0;
            cnt_q      <= '0;
            step_out_q <= '0;
            set_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            stop_q     <= stop_d;
            inc_q      <= inc_d;
            dwell_q    <= dwell_d;
            cnt_q      <= cnt_d;
            step_out_q <= step_out_d;
            set_q      <= set_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign step_out = step_out_q;
    assign SET      = set_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: expected cycle records are queued at
// launch and compared one per clock after each rising edge.
module tb_dds_sweep_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        start;
    logic        abort;
    logic [7:0]  start_step;
    logic [7:0]  stop_step;
    logic [7:0]  step_inc;
    logic [15:0] dwell;
    logic        zero_address;
    logic [7:0]  step_out;
    logic        SET;
    logic        busy;
    logic        done;

    typedef struct {
        logic       set;
        logic [7:0] so;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t       sb[$];
    int         n_chk  = 0;
    int         n_pass = 0;
    logic [7:0] last_so = 8'd0;
    int         zcnt = 0;

    dds_sweep_ctrl #(.ADDRESS_WIDTH(8), .DWELL_WIDTH(16)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .abort(abort),
        .start_step(start_step), .stop_step(stop_step),
        .step_inc(step_inc), .dwell(dwell), .zero_address(zero_address),
        .step_out(step_out), .SET(SET), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        zcnt <= (zcnt == 15) ? 0 : zcnt + 1;
        zero_address <= (zcnt == 15);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    endtask

    task automatic push_rec(input logic s, input logic [7:0] so,
                            input logic b, input logic d);
        exp_t r;
        r.set = s; r.so = so; r.busy = b; r.done = d;
        sb.push_back(r);
    endtask

    // Expected timeline: SET every D+2 cycles from cycle 1, done at N*(D+2)+1
    task automatic push_sweep(input int s, input int e, input int inc,
                              input int dw, input int cut, input int tail);
        int pts[$];
        int p, d, ie, per, total;
        d  = (dw == 0) ? 1 : dw;
        ie = (inc == 0) ? 1 : inc;
        p  = s;
        pts.push_back(p);
        while (p < e) begin
            p = (p + ie > e) ? e : p + ie;
            pts.push_back(p);
        end
        per   = d + 2;
        total = pts.size() * per + 1;
        for (int k = 1; k <= total; k++) begin
            if (cut != 0 && k > cut) break;
            if ((k - 1) % per == 0 && k < total) begin
                last_so = 8'(pts[(k - 1) / per]);
                push_rec(1'b1, last_so, 1'b1, 1'b0);
            end else begin
                push_rec(1'b0, last_so, 1'b1, k == total);
            end
        end
        for (int k = 0; k < tail; k++) push_rec(1'b0, last_so, 1'b0, 1'b0);
    endtask

    task automatic launch(input int s, input int e, input int inc,
                          input int dw, input logic ab);
        start_step = 8'(s);
        stop_step  = 8'(e);
        step_inc   = 8'(inc);
        dwell      = 16'(dw);
        start      = 1'b1;
        abort      = ab;
    endtask

    task automatic drain(input int n, input int abort_at);
        exp_t r;
        for (int i = 1; i <= n; i++) begin
            @(posedge CLK);
            #1;
            start      = 1'b0;
            abort      = 1'b0;
            start_step = 8'($urandom);
            stop_step  = 8'($urandom);
            step_inc   = 8'($urandom);
            dwell      = 16'($urandom);
            if (sb.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                r = sb.pop_front();
                chk($sformatf("set@%0d", i), 32'(SET), 32'(r.set));
                chk($sformatf("step_out@%0d", i), 32'(step_out), 32'(r.so));
                chk($sformatf("busy@%0d", i), 32'(busy), 32'(r.busy));
                chk($sformatf("done@%0d", i), 32'(done), 32'(r.done));
            end
            if (i == abort_at) abort = 1'b1;
        end
    endtask

    initial begin
        RESET = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        start_step = '0;
        stop_step  = '0;
        step_inc   = '0;
        dwell      = '0;
        zero_address = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_step_out", 32'(step_out), 32'd0);
        chk("rst_set", 32'(SET), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        RESET = 1'b0;

        // 3..9 by 3, dwell 2: SET at 1/5/9, done at 13
        launch(3, 9, 3, 2, 1'b0);
        push_sweep(3, 9, 3, 2, 0, 3);
        drain(16, 0);

        // dwell 0 acts as 1: points 1,5,9,10
        launch(1, 10, 4, 0, 1'b0);
        push_sweep(1, 10, 4, 0, 0, 2);
        drain(15, 0);

        // Near full scale: 250 then clamped 255, no wrap
        launch(250, 255, 10, 1, 1'b0);
        push_sweep(250, 255, 10, 1, 0, 2);
        drain(9, 0);

        // start > stop: single point
        launch(9, 3, 1, 3, 1'b0);
        push_sweep(9, 3, 1, 3, 0, 2);
        drain(8, 0);

        // Abort in DWELL of second point (cycle 6)
        launch(3, 9, 3, 2, 1'b0);
        push_sweep(3, 9, 3, 2, 6, 8);
        drain(14, 6);

        // start with abort in IDLE: stays idle
        launch(20, 30, 1, 1, 1'b1);
        for (int k = 0; k < 3; k++) push_rec(1'b0, last_so, 1'b0, 1'b0);
        drain(3, 0);

        // Reset mid-sweep, then a clean rerun
        launch(1, 10, 4, 0, 1'b0);
        push_sweep(1, 10, 4, 0, 4, 0);
        drain(4, 0);
        RESET = 1'b1;
        last_so = 8'd0;
        push_rec(1'b0, 8'd0, 1'b0, 1'b0);
        drain(1, 0);
        RESET = 1'b0;
        launch(1, 10, 4, 0, 1'b0);
        push_sweep(1, 10, 4, 0, 0, 2);
        drain(15, 0);

        // inc 0 acts as 1
        launch(100, 102, 0, 1, 1'b0);
        push_sweep(100, 102, 0, 1, 0, 2);
        drain(12, 0);

        if (sb.size() != 0) chk("sb_leftover", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
